rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Owns the single write port (we/rW/din) of the RegFile; shares it between two write-back requesters.
  - Port 0: main pipeline WB.
  - Port 1: multi-cycle unit, e.g. load/div.
- Fixed priority to port 0, with an anti-starvation escalation for port 1.
- Keeps a per-register scoreboard of pending multi-cycle writes. The decode stage queries it for RAW hazards on rA/rB.

Parameters:
- WIDTH, 32: register data width; matches RegFile WIDTH.
- MAX_WAIT, 4: consecutive stalled cycles of port 1 after which port 1 is forced to win. Range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb0_valid  in  1  port 0 write request.
- wb0_ready  out  1  port 0 accepted this cycle when wb0_valid & wb0_ready.
- wb0_rd  in  5  port 0 destination register.
- wb0_data  in  WIDTH  port 0 write data.
- wb1_valid  in  1  port 1 write request.
- wb1_ready  out  1  port 1 accept.
- wb1_rd  in  5  port 1 destination register.
- wb1_data  in  WIDTH  port 1 write data.
- iss_valid  in  1  a multi-cycle op targeting iss_rd is issued; marks it pending.
- iss_rd  in  5  destination of the issued op.
- q_rA  in  5  decode source A query.
- q_rB  in  5  decode source B query.
- q_busyA  out  1  q_rA has a pending/in-flight write.
- q_busyB  out  1  q_rB has a pending/in-flight write.
- rf_we  out  1  to RegFile we (registered).
- rf_rW  out  5  to RegFile rW (registered).
- rf_din  out  WIDTH  to RegFile din (registered).

Behaviour:
- Reset: all outputs are 0 on reset. This covers rf_we, rf_rW, rf_din, the ready signals (0 while rst high) and busy. The scoreboard (31 bits, x1..x31) and wait counter are cleared. Reset mid-request drops the request; no RegFile write occurs.
- Handshake: a requester holds valid/rd/data stable until accepted. Transfer = valid & ready in the same cycle.
- force1 is a combinational flag: force1 = (wait_cnt == MAX_WAIT) & wb1_valid.
- Ready logic (combinational, not dependent on own valid):
  - wb0_ready = !force1.
  - wb1_ready = force1 | !wb0_valid.
  - At most one transfer per cycle.
- Wait counter (4 bits):
  - Increments when wb1_valid & !wb1_ready.
  - Clears on a port 1 transfer or when wb1_valid is low.
  - Saturates at MAX_WAIT.
- Latency: one cycle. On the edge after a transfer, rf_we=1 and rf_rW/rf_din = winner rd/data. With no transfer, rf_we=0 and rf_rW/rf_din hold their old values. The RegFile commits on the following edge.
- x0: a transfer with rd==0 completes the handshake, but rf_we stays 0 and the scoreboard is untouched.
- Scoreboard set: iss_valid with iss_rd!=0 sets sb[iss_rd] at the edge.
- Scoreboard clear: a port 1 transfer clears sb[wb1_rd] at the same edge that loads rf_we. Port 0 transfers never clear the scoreboard.
- Simultaneous set and clear of the same register: set wins; a new op was issued.
- Busy: q_busyX = (q_rX!=0) & (sb[q_rX] | (rf_we & rf_rW==q_rX)).
  - Purely combinational from registered state.
  - Covers the one cycle where the write is in the output register but not yet in the RegFile.
- No internal FSM beyond the counter. The arbiter is stateless per transfer; the only state is the counter, scoreboard and output register.

Test Plan:
- Reset, then wb0 writes x5=0xDEADBEEF. The cycle after the transfer: rf_we=1, rf_rW=5, rf_din=0xDEADBEEF. The next cycle: rf_we=0.
- iss x10, then q_rB=10 reads busyB=1. wb1 writes x10=0xCAFEBABE. busyB stays 1 during the rf_we cycle, then drops to 0 one cycle later.
- wb0 and wb1 both valid continuously, wb1_rd=7:
  - wb0 is accepted for 4 cycles.
  - On the 5th cycle wb1_ready=1 and wb0_ready=0.
  - rf_rW=7 appears the following cycle and the counter returns to 0.
- wb0 writes rd=0 with data 0x12345678: wb0_ready=1 and the transfer completes, with rf_we=0 throughout. iss_rd=0 leaves busy at 0 for q_rA=0.
- iss_valid for x3 in the same cycle as a wb1 transfer to x3: sb[3] stays 1. After a later wb1 write to x3, sb[3]=0.
- rst asserted while wb1_valid is pending with the counter at 3: ready=0, counter=0, scoreboard cleared. No rf_we pulse on the following edge.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the RegFile write port between the main WB (port 0)
// and a multi-cycle unit (port 1). Port 0 has priority; port 1 is forced
// through after MAX_WAIT stalled cycles. Tracks pending multi-cycle
// destinations in a scoreboard for decode RAW checks.
module rf_wb_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb0_valid,
    output logic             wb0_ready,
    input  logic [4:0]       wb0_rd,
    input  logic [WIDTH-1:0] wb0_data,
    input  logic             wb1_valid,
    output logic             wb1_ready,
    input  logic [4:0]       wb1_rd,
    input  logic [WIDTH-1:0] wb1_data,
    input  logic             iss_valid,
    input  logic [4:0]       iss_rd,
    input  logic [4:0]       q_rA,
    input  logic [4:0]       q_rB,
    output logic             q_busyA,
    output logic             q_busyB,
    output logic             rf_we,
    output logic [4:0]       rf_rW,
    output logic [WIDTH-1:0] rf_din
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0]       wait_cnt;
    logic [31:1]      sb;
    logic [31:0]      sb_full;
    logic [31:0]      sb_nxt;
    logic             force1;
    logic             xfer0;
    logic             xfer1;
    logic             win;
    logic [4:0]       win_rd;
    logic [WIDTH-1:0] win_data;

    // x0 never has a pending write, so bit 0 of the widened view is tied low
    assign sb_full = {sb, 1'b0};

    // Arbitration: port 0 wins unless port 1 has waited MAX_WAIT cycles
    always_comb begin
        force1    = (wait_cnt == MAX_W) && wb1_valid;
        wb0_ready = !rst && !force1;
        wb1_ready = !rst && (force1 || !wb0_valid);
        xfer0     = wb0_valid && wb0_ready;
        xfer1     = wb1_valid && wb1_ready;
        win       = xfer0 || xfer1;
        win_rd    = xfer1 ? wb1_rd   : wb0_rd;
        win_data  = xfer1 ? wb1_data : wb0_data;
    end

    // Busy covers both pending ops and the write sitting in the output register
    always_comb begin
        q_busyA = !rst && (q_rA != 5'd0) && (sb_full[q_rA] || (rf_we && rf_rW == q_rA));
        q_busyB = !rst && (q_rB != 5'd0) && (sb_full[q_rB] || (rf_we && rf_rW == q_rB));
    end

    // Scoreboard next state: clear on port 1 completion, then set on issue so set wins
    always_comb begin
        sb_nxt = sb_full;
        if (xfer1 && wb1_rd != 5'd0)
            sb_nxt[wb1_rd] = 1'b0;
        if (iss_valid && iss_rd != 5'd0)
            sb_nxt[iss_rd] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) sb <= '0;
        else     sb <= sb_nxt[31:1];
    end

    // Port 1 starvation counter: counts stalled cycles, saturates at MAX_WAIT
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (!wb1_valid || xfer1)
            wait_cnt <= '0;
        else if (wait_cnt != MAX_W)
            wait_cnt <= wait_cnt + 4'd1;
    end

    // Registered write port; rd==0 transfers complete but never write
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we  <= 1'b0;
            rf_rW  <= '0;
            rf_din <= '0;
        end else begin
            rf_we <= win && (win_rd != 5'd0);
            if (win && win_rd != 5'd0) begin
                rf_rW  <= win_rd;
                rf_din <= win_data;
            end
        end
    end

endmodule
